// File: rtl/branch_pkg.sv
// Shared types and constants for the fetch-side branch redirect logic and its predictor.
package branch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } redirect_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_next;
  } pred_entry_t;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Fetch/execute/hazard-side signal bundle of branch_redirect_ctrl.
interface branch_redirect_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned QDEPTH     = 4
);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  logic                  f_valid;
  logic                  f_is_ctrl;
  logic [DATA_WIDTH-1:0] f_pc;
  logic                  f_predict_taken;
  logic [DATA_WIDTH-1:0] f_pred_target;
  logic                  stall_in;
  logic                  e_valid;
  logic                  e_is_ctrl;
  logic                  e_taken;
  logic [DATA_WIDTH-1:0] e_target;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  fetch_hold;
  logic                  flush;
  logic                  mispredict;
  logic [CNT_W-1:0]      q_count;
  logic                  proto_err;

  modport master (
    output f_valid, f_is_ctrl, f_pc, f_predict_taken, f_pred_target, stall_in,
    output e_valid, e_is_ctrl, e_taken, e_target,
    input  pc_next, fetch_hold, flush, mispredict, q_count, proto_err
  );

  modport slave (
    input  f_valid, f_is_ctrl, f_pc, f_predict_taken, f_pred_target, stall_in,
    input  e_valid, e_is_ctrl, e_taken, e_target,
    output pc_next, fetch_hold, flush, mispredict, q_count, proto_err
  );

endinterface

// File: rtl/pred_queue.sv
// In-order prediction FIFO with synchronous clear; DEPTH must be a power of two.
module pred_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Tracks fetch-stage predictions, checks them at execute, and redirects/flushes on a mispredict.
// Optional BRANCH_REDIRECT_STATS_EN adds saturating resolve/mispredict counters.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = XLEN,
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  branch_redirect_ctrl_if.slave   bus
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [31:0]             stat_resolved,
  output logic [31:0]             stat_mispred
`endif
);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

  if (DATA_WIDTH != XLEN) begin : g_width_check
    $error("DATA_WIDTH must equal branch_pkg::XLEN");
  end

  redirect_state_t       r_state;
  logic [FC_W-1:0]       r_flush_cnt;
  logic                  r_mispredict;
  logic                  r_redirect_valid;
  logic [DATA_WIDTH-1:0] r_redirect_pc;
  logic                  r_proto_err;

  pred_entry_t           w_push_entry;
  pred_entry_t           w_head;
  logic [$bits(pred_entry_t)-1:0] w_head_bits;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic                  w_run;
  logic                  w_pop_req;
  logic                  w_pop;
  logic                  w_err;
  logic                  w_push;
  logic                  w_misp;
  logic [DATA_WIDTH-1:0] w_actual_next;

  assign w_run     = (r_state == RUN);
  assign w_pop_req = w_run & bus.e_valid & bus.e_is_ctrl;
  assign w_pop     = w_pop_req & ~w_empty;
  assign w_err     = w_pop_req & w_empty;

  assign bus.fetch_hold = w_full & ~w_pop;

  assign w_head        = pred_entry_t'(w_head_bits);
  assign w_actual_next = bus.e_taken ? bus.e_target : (w_head.pc + DATA_WIDTH'(4));
  assign w_misp        = w_pop & (w_actual_next != w_head.pred_next);

  // A push alongside a mispredicting pop is wrong-path and is dropped.
  assign w_push = w_run & bus.f_valid & bus.f_is_ctrl & ~bus.stall_in &
                  ~bus.fetch_hold & ~w_misp;

  assign w_push_entry = '{pc:        bus.f_pc,
                          pred_next: bus.f_predict_taken ? bus.f_pred_target
                                                         : (bus.f_pc + DATA_WIDTH'(4))};

  pred_queue #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(pred_entry_t))
  ) u_pred_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_clear   (w_misp),
    .i_wr_data (w_push_entry),
    .o_rd_data (w_head_bits),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= RUN;
      r_flush_cnt      <= '0;
      r_mispredict     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_proto_err      <= 1'b0;
    end else begin
      r_mispredict     <= w_misp;
      r_redirect_valid <= w_misp;
      if (w_misp) r_redirect_pc <= w_actual_next;
      if (w_err)  r_proto_err   <= 1'b1;
      case (r_state)
        RUN: begin
          if (w_misp) begin
            r_state     <= FLUSH;
            r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (r_flush_cnt == '0) r_state     <= RUN;
          else                   r_flush_cnt <= r_flush_cnt - FC_W'(1);
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.flush      = (r_state == FLUSH);
  assign bus.mispredict = r_mispredict;
  assign bus.proto_err  = r_proto_err;
  assign bus.q_count    = w_count;
  assign bus.pc_next    = r_redirect_valid ? r_redirect_pc :
                          (bus.f_valid & bus.f_predict_taken) ? bus.f_pred_target :
                          (bus.f_pc + DATA_WIDTH'(4));

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] r_stat_resolved;
  logic [31:0] r_stat_mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else begin
      if (w_pop && (r_stat_resolved != '1)) r_stat_resolved <= r_stat_resolved + 32'(1);
      if (w_misp && (r_stat_mispred != '1)) r_stat_mispred  <= r_stat_mispred + 32'(1);
    end
  end

  assign stat_resolved = r_stat_resolved;
  assign stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench: stimulus schedules expected values per cycle; a negedge monitor checks them.
module tb_branch_redirect_ctrl;
  localparam int unsigned DW = 32;
  localparam int unsigned QD = 4;
  localparam int unsigned FC = 2;

  localparam int S_PC    = 0;
  localparam int S_FLUSH = 1;
  localparam int S_MISP  = 2;
  localparam int S_HOLD  = 3;
  localparam int S_QCNT  = 4;
  localparam int S_PERR  = 5;
`ifdef BRANCH_REDIRECT_STATS_EN
  localparam int S_STATR = 6;
  localparam int S_STATM = 7;
`endif

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  chk_t        sb[$];
  logic [31:0] misp_q[$];
  logic [31:0] mon_act;
  logic [31:0] mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_redirect_ctrl_if #(.DATA_WIDTH(DW), .QDEPTH(QD)) bus ();

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
`endif

  branch_redirect_ctrl #(
    .DATA_WIDTH   (DW),
    .QDEPTH       (QD),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus)
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      S_PC:    return bus.pc_next;
      S_FLUSH: return 32'(bus.flush);
      S_MISP:  return 32'(bus.mispredict);
      S_HOLD:  return 32'(bus.fetch_hold);
      S_QCNT:  return 32'(bus.q_count);
      S_PERR:  return 32'(bus.proto_err);
`ifdef BRANCH_REDIRECT_STATS_EN
      S_STATR: return stat_resolved;
      S_STATM: return stat_mispred;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Scoreboard monitor: scheduled per-cycle checks plus every mispredict pulse.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        mon_act = probe(sb[i].sel);
        n_tests++;
        if (mon_act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d actual=%0h expected=%0h", sb[i].name, cyc, mon_act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
    if (bus.mispredict === 1'b1) begin
      n_tests++;
      if (misp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_mispredict cyc=%0d actual=1 expected=0", cyc);
      end else begin
        mon_exp = misp_q.pop_front();
        if (bus.pc_next !== mon_exp) begin
          n_fail++;
          $display("FAIL redirect_target cyc=%0d actual=%0h expected=%0h", cyc, bus.pc_next, mon_exp);
        end
      end
    end
  end

  task automatic chk(input int unsigned dc, input int sel, input logic [31:0] v, input string nm);
    chk_t c;
    c.cyc  = cyc + dc;
    c.sel  = sel;
    c.exp  = v;
    c.name = nm;
    sb.push_back(c);
  endtask

  task automatic idle();
    bus.f_valid         = 1'b0;
    bus.f_is_ctrl       = 1'b0;
    bus.f_pc            = 32'h500;
    bus.f_predict_taken = 1'b0;
    bus.f_pred_target   = 32'h0;
    bus.stall_in        = 1'b0;
    bus.e_valid         = 1'b0;
    bus.e_is_ctrl       = 1'b0;
    bus.e_taken         = 1'b0;
    bus.e_target        = 32'h0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic fetch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bus.f_valid         = 1'b1;
    bus.f_is_ctrl       = 1'b1;
    bus.f_pc            = pc;
    bus.f_predict_taken = tk;
    bus.f_pred_target   = tgt;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    bus.e_valid   = 1'b1;
    bus.e_is_ctrl = 1'b1;
    bus.e_taken   = tk;
    bus.e_target  = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset state
    cycle();
    chk(0, S_QCNT, 0, "rst_qcount");
    chk(0, S_FLUSH, 0, "rst_flush");
    chk(0, S_MISP, 0, "rst_misp");
    chk(0, S_PERR, 0, "rst_proto_err");
    chk(0, S_HOLD, 0, "rst_fetch_hold");
    chk(0, S_PC, 32'h504, "rst_pc_next");

    // Backward branch predicted taken, resolved taken
    cycle(); fetch(32'h100, 1'b1, 32'h0F0);
    chk(0, S_PC, 32'h0F0, "t1_pc_pred_taken");
    chk(1, S_QCNT, 1, "t1_qcount_push");
    cycle(); resolve(1'b1, 32'h0F0);
    chk(1, S_QCNT, 0, "t1_qcount_pop");
    chk(1, S_MISP, 0, "t1_no_misp");
    chk(1, S_FLUSH, 0, "t1_no_flush");
    chk(2, S_FLUSH, 0, "t1_no_flush_late");
    cycle(); cycle();

    // Forward branch predicted not-taken, resolved taken
    cycle(); fetch(32'h200, 1'b0, 32'h999);
    chk(0, S_PC, 32'h204, "t2_pc_not_taken");
    cycle(); resolve(1'b1, 32'h240);
    misp_q.push_back(32'h240);
    chk(0, S_MISP, 0, "t2_misp_not_yet");
    chk(1, S_MISP, 1, "t2_misp_pulse");
    chk(1, S_PC, 32'h240, "t2_redirect_pc");
    chk(1, S_FLUSH, 1, "t2_flush_c1");
    chk(1, S_QCNT, 0, "t2_qcount_cleared");
    chk(2, S_FLUSH, 1, "t2_flush_c2");
    chk(2, S_MISP, 0, "t2_misp_one_cycle");
    chk(2, S_PC, 32'h504, "t2_no_residual_redirect");
    chk(3, S_FLUSH, 0, "t2_flush_end");
    cycle(); cycle(); cycle();

    // JAL, then mispredicting pop with a same-cycle wrong-path push
    cycle(); fetch(32'h300, 1'b1, 32'h400);
    chk(0, S_PC, 32'h400, "t3_jal_pc");
    cycle(); fetch(32'h400, 1'b0, 32'h0); resolve(1'b1, 32'h400);
    chk(0, S_QCNT, 1, "t3_qcount_before");
    chk(1, S_QCNT, 1, "t3_push_pop_same");
    cycle(); fetch(32'h404, 1'b0, 32'h0); resolve(1'b1, 32'h480);
    misp_q.push_back(32'h480);
    chk(0, S_PC, 32'h408, "t3_pc_fallthrough");
    chk(1, S_PC, 32'h480, "t3_redirect_pc");
    chk(1, S_QCNT, 0, "t3_wrongpath_discard");
    chk(3, S_QCNT, 0, "t3_qcount_after_flush");
    chk(3, S_FLUSH, 0, "t3_flush_end");
    cycle(); fetch(32'h480, 1'b0, 32'h0);
    cycle(); cycle();

    // Fill the queue, blocked push, then simultaneous push/pop and drain
    cycle(); fetch(32'h600, 1'b0, 32'h0);
    cycle(); fetch(32'h604, 1'b0, 32'h0);
    cycle(); fetch(32'h608, 1'b0, 32'h0);
    cycle(); fetch(32'h60C, 1'b0, 32'h0);
    chk(0, S_QCNT, 3, "t4_qcount3");
    chk(0, S_HOLD, 0, "t4_hold_at3");
    cycle(); fetch(32'h610, 1'b0, 32'h0);
    chk(0, S_QCNT, 4, "t4_full");
    chk(0, S_HOLD, 1, "t4_hold_full");
    chk(0, S_PC, 32'h614, "t4_pc_fallthrough");
    cycle(); fetch(32'h610, 1'b0, 32'h0); resolve(1'b0, 32'h0);
    chk(0, S_QCNT, 4, "t4_blocked_push");
    chk(0, S_HOLD, 0, "t4_hold_drop_on_pop");
    cycle(); resolve(1'b0, 32'h0);
    chk(0, S_QCNT, 4, "t4_pushpop_keeps4");
    cycle(); resolve(1'b0, 32'h0);
    chk(0, S_QCNT, 3, "t4_drain3");
    cycle(); resolve(1'b0, 32'h0);
    chk(0, S_QCNT, 2, "t4_drain2");
    cycle(); resolve(1'b0, 32'h0);
    chk(0, S_QCNT, 1, "t4_drain1");
    chk(1, S_QCNT, 0, "t4_drained");
    chk(1, S_MISP, 0, "t4_no_misp");
    cycle();

    // Stall blocks a push
    cycle(); fetch(32'h800, 1'b0, 32'h0); bus.stall_in = 1'b1;
    chk(1, S_QCNT, 0, "stall_blocks_push");
    cycle();

    // Resolve with an empty queue
    cycle(); resolve(1'b1, 32'h123);
    chk(0, S_PERR, 0, "t5_perr_pre");
    chk(1, S_PERR, 1, "t5_perr_set");
    chk(1, S_MISP, 0, "t5_no_misp");
    chk(1, S_FLUSH, 0, "t5_no_flush");
    chk(1, S_QCNT, 0, "t5_qcount");
    chk(3, S_PERR, 1, "t5_perr_sticky");
    cycle(); cycle(); cycle();
`ifdef BRANCH_REDIRECT_STATS_EN
    chk(0, S_STATR, 9, "stat_resolved_count");
    chk(0, S_STATM, 2, "stat_mispred_count");
`endif

    // Asynchronous reset during the second flush cycle
    cycle(); fetch(32'h700, 1'b0, 32'h0);
    cycle(); resolve(1'b1, 32'h780);
    misp_q.push_back(32'h780);
    chk(1, S_FLUSH, 1, "t6_flush_c1");
    cycle();
    cycle();
    chk(0, S_FLUSH, 0, "t6_rst_flush");
    chk(0, S_MISP, 0, "t6_rst_misp");
    chk(0, S_QCNT, 0, "t6_rst_qcount");
    chk(0, S_PERR, 0, "t6_rst_perr_cleared");
    chk(0, S_PC, 32'h504, "t6_rst_pc_next");
`ifdef BRANCH_REDIRECT_STATS_EN
    chk(0, S_STATR, 0, "t6_rst_stat_resolved");
    chk(0, S_STATM, 0, "t6_rst_stat_mispred");
`endif
    #1 rst_n = 1'b0;
    cycle();
    #2 rst_n = 1'b1;
    chk(1, S_FLUSH, 0, "t6_post_rst_flush");
    chk(1, S_PC, 32'h504, "t6_post_rst_pc");
    chk(1, S_PERR, 0, "t6_post_rst_perr");
    cycle(); cycle(); cycle();

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover actual=%0d expected=0", sb.size());
    end
    n_tests++;
    if (misp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_mispredict actual=%0d pending expected=0", misp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
